// File: rtl/data_mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
// Holds the FSM state encoding and the word/alignment definitions.
package data_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int          WORD_W          = 32;
    localparam logic [31:0] ADDR_ALIGN_MASK = 32'h0000_0003;

endpackage

// File: rtl/data_mem_array.sv
// Single-port word RAM: synchronous write, registered read, both gated by en.
// Contents are deliberately left unreset so the array maps onto block RAM.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              Clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  index,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge Clk) begin
        if (en) begin
            if (we) begin
                r_mem[index] <= wdata;
            end
            r_rdata <= r_mem[index];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the MEM stage: accepts one word access per handshake,
// waits LATENCY cycles, then pulses a response carrying read data and an error flag.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Req_valid,
    input  logic              Req_WE,
    input  logic [31:0]       Req_Addr,
    input  logic [WORD_W-1:0] Req_WData,
    output logic              Req_ready,
    output logic              Resp_valid,
    output logic [WORD_W-1:0] Resp_RData,
    output logic              Resp_Err,
    output logic              Stall
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT_CNT   = 4'(LATENCY);
    localparam logic [29:0] DEPTH_W30 = 30'(DEPTH_WORDS);

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic                r_err;
    logic [IDX_W-1:0]    r_idx;
    logic [WORD_W-1:0]   r_wdata;

    logic                w_accept;
    logic                w_req_err;
    logic                w_commit;
    logic                w_c_we;
    logic                w_c_err;
    logic [IDX_W-1:0]    w_c_idx;
    logic [WORD_W-1:0]   w_c_wdata;
    logic [WORD_W-1:0]   w_rdata;

    assign w_accept  = Req_valid & Req_ready;
    assign w_req_err = ((Req_Addr & ADDR_ALIGN_MASK) != 32'd0) | (Req_Addr[31:2] >= DEPTH_W30);

    // With zero latency the RESP-entry edge is the accept edge, so the array is fed
    // straight from the request; otherwise it is fed from the latched request.
    assign w_commit  = (LATENCY == 0) ? w_accept
                                      : ((r_state == ST_BUSY) && (r_cnt <= 4'd1));
    assign w_c_we    = (LATENCY == 0) ? Req_WE                 : r_we;
    assign w_c_err   = (LATENCY == 0) ? w_req_err              : r_err;
    assign w_c_idx   = (LATENCY == 0) ? Req_Addr[IDX_W+1:2]    : r_idx;
    assign w_c_wdata = (LATENCY == 0) ? Req_WData              : r_wdata;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_cnt   <= LAT_CNT;
                r_we    <= Req_WE;
                r_err   <= w_req_err;
                r_idx   <= Req_Addr[IDX_W+1:2];
                r_wdata <= Req_WData;
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        Req_ready    = 1'b1;
        Resp_valid   = 1'b0;
        Stall        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                Stall = Req_valid;
                if (w_accept) begin
                    w_next_state = (LATENCY == 0) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                Req_ready = 1'b0;
                Stall     = 1'b1;
                if (r_cnt <= 4'd1) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                Resp_valid = 1'b1;
                if (w_accept) begin
                    w_next_state = (LATENCY == 0) ? ST_RESP : ST_BUSY;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .Clk   (Clk),
        .en    (w_commit),
        .we    (w_c_we & ~w_c_err),
        .index (w_c_idx),
        .wdata (w_c_wdata),
        .rdata (w_rdata)
    );

    // Read data is only meaningful for a clean load in its response cycle.
    assign Resp_RData = ((r_state == ST_RESP) && !r_we && !r_err) ? w_rdata : '0;
    assign Resp_Err   = (r_state == ST_RESP) & r_err;

endmodule
